// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue controller: widths, error codes,
// response flag bit positions and the controller state encoding.
package alu_pkg;

  localparam int DATA_W      = 8;
  localparam int NUM_OPCODES = 20;
  localparam int OPC_W       = 5;
  localparam int FLAGS_W     = 5;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_OPC = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  // Bit positions inside rsp_flags = {overflow, negative, zero, borrow, carry}
  localparam int FLG_CARRY  = 0;
  localparam int FLG_BORROW = 1;
  localparam int FLG_ZERO   = 2;
  localparam int FLG_NEG    = 3;
  localparam int FLG_OVF    = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Host-facing initiator for the 8-bit ALU: accepts one command, strobes it into
// the ALU, waits (bounded) for the result and returns result, flags and status.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W         = alu_pkg::DATA_W,
  parameter int NUM_OPCODES    = alu_pkg::NUM_OPCODES,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OPC_W-1:0]         cmd_opcode,
  input  logic signed [DATA_W-1:0] cmd_a,
  input  logic signed [DATA_W-1:0] cmd_b,
  input  logic                     cmd_chain,
  output logic                     alu_enable,
  output logic                     alu_input_ready,
  output logic [OPC_W-1:0]         alu_opcode,
  output logic signed [DATA_W-1:0] alu_operand_A,
  output logic signed [DATA_W-1:0] alu_operand_B,
  output logic                     alu_carry_in,
  output logic                     alu_borrow_in,
  input  logic [DATA_W-1:0]        alu_result_out,
  input  logic                     alu_result_ready,
  input  logic                     alu_carry_out,
  input  logic                     alu_borrow_out,
  input  logic                     alu_zero,
  input  logic                     alu_negative,
  input  logic                     alu_overflow,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_result,
  output logic [FLAGS_W-1:0]       rsp_flags,
  output logic [1:0]               rsp_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flag_c;
  logic             r_flag_b;

  logic             w_opc_legal;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_opc_legal = (32'(cmd_opcode) < NUM_OPCODES);
  assign w_cnt_nxt   = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_flag_c        <= 1'b0;
      r_flag_b        <= 1'b0;
      cmd_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      alu_enable      <= 1'b0;
      alu_input_ready <= 1'b0;
      alu_opcode      <= '0;
      alu_operand_A   <= '0;
      alu_operand_B   <= '0;
      alu_carry_in    <= 1'b0;
      alu_borrow_in   <= 1'b0;
      rsp_result      <= '0;
      rsp_flags       <= '0;
      rsp_err         <= ERR_OK;
    end else begin
      alu_input_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (w_opc_legal) begin
              // Chain inputs are resolved here; the flag register cannot change before ISSUE.
              alu_opcode      <= cmd_opcode;
              alu_operand_A   <= cmd_a;
              alu_operand_B   <= cmd_b;
              alu_carry_in    <= cmd_chain & r_flag_c;
              alu_borrow_in   <= cmd_chain & r_flag_b;
              alu_enable      <= 1'b1;
              alu_input_ready <= 1'b1;
              r_state         <= ISSUE;
            end else begin
              rsp_valid  <= 1'b1;
              rsp_err    <= ERR_OPC;
              rsp_result <= '0;
              rsp_flags  <= '0;
              r_state    <= RESP;
            end
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (alu_result_ready) begin
            rsp_result <= alu_result_out;
            rsp_flags  <= {alu_overflow, alu_negative, alu_zero, alu_borrow_out, alu_carry_out};
            rsp_err    <= ERR_OK;
            r_flag_c   <= alu_carry_out;
            r_flag_b   <= alu_borrow_out;
            rsp_valid  <= 1'b1;
            alu_enable <= 1'b0;
            r_state    <= RESP;
          end else if (w_cnt_nxt == CNT_LAST) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= ERR_TMO;
            rsp_valid  <= 1'b1;
            alu_enable <= 1'b0;
            r_state    <= RESP;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
